// File: rtl/rx_stream_framer.sv
// rx_stream_framer
//   Buffers words from the SPI receiver in a small FIFO and re-emits them as an
//   AXI4-Stream with TLAST framing. A frame closes after FRAME_LEN words, or
//   early when the input stays idle for TIMEOUT cycles. One word is always kept
//   in a hold register so that a word released by a timeout can carry TLAST.
//
//   Ports
//     aclk, aresetn   clock, asynchronous active-low reset
//     in_data/valid   word from the receiver; in_ready = FIFO not full
//     m_axis_*        AXI4-Stream master (tdata, tvalid, tready, tlast)
//     fifo_level      words in the FIFO, not counting the hold register
//     frame_cnt       completed frames (TLAST handshakes), wraps at 16 bits
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_EMPTY | hold register empty; pop the next FIFO word when one exists
//   ST_HOLD  | word held, no successor yet; run the idle timer
//   ST_SEND  | held word presented on the stream, waiting for tready
module rx_stream_framer #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 64,
   parameter int TIMEOUT   = 1024
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [15:0]              frame_cnt
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LW    = AW + 1;
   localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

   typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_SEND} state_t;

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [LW-1:0]      level;
   logic [IDX_W-1:0]   idx, idx_nxt, idx_inc;
   logic [TMR_W-1:0]   timer, timer_nxt;
   logic [DATA_W-1:0]  hold_data;
   logic               last_r, last_nxt;
   logic [15:0]        frame_cnt_r;
   logic               run;
   logic               push, pop, level_nz, level_ge2, idx_is_last, tmo;

   assign in_ready    = run && (level != LVL_FULL);
   assign push        = in_valid && in_ready;
   assign level_nz    = (level != '0);
   assign level_ge2   = (level >= LW'(2));
   assign idx_is_last = (idx == IDX_LAST);
   assign tmo         = (timer == TMR_LAST);
   // A frame-last word always restarts the position count.
   assign idx_inc     = last_r ? '0 : idx + IDX_W'(1);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      last_nxt  = last_r;
      idx_nxt   = idx;
      timer_nxt = timer;
      case (state)
         ST_EMPTY: begin
            timer_nxt = '0;
            if (level_nz) begin
               pop = 1'b1;
               // Go straight out only if the word already knows its TLAST value.
               if (level_ge2 || idx_is_last) begin
                  state_nxt = ST_SEND;
                  last_nxt  = idx_is_last;
               end else begin
                  state_nxt = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            timer_nxt = timer + TMR_W'(1);
            if (level_nz || idx_is_last || tmo) begin
               state_nxt = ST_SEND;
               last_nxt  = idx_is_last || tmo;
               timer_nxt = '0;
            end
         end
         ST_SEND: begin
            if (m_axis_tready) begin
               idx_nxt = idx_inc;
               if (level_ge2) begin
                  pop      = 1'b1;
                  last_nxt = (idx_inc == IDX_LAST);
               end else if (level_nz) begin
                  pop = 1'b1;
                  if (idx_inc == IDX_LAST) begin
                     last_nxt = 1'b1;
                  end else begin
                     state_nxt = ST_HOLD;
                     last_nxt  = 1'b0;
                  end
               end else begin
                  state_nxt = ST_EMPTY;
                  last_nxt  = 1'b0;
               end
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= ST_EMPTY;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         idx         <= '0;
         timer       <= '0;
         hold_data   <= '0;
         last_r      <= 1'b0;
         frame_cnt_r <= '0;
         run         <= 1'b0;
      end else begin
         run    <= 1'b1;
         state  <= state_nxt;
         idx    <= idx_nxt;
         timer  <= timer_nxt;
         last_r <= last_nxt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            hold_data <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
            frame_cnt_r <= frame_cnt_r + 16'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   assign m_axis_tvalid = (state == ST_SEND);
   assign m_axis_tdata  = hold_data;
   assign m_axis_tlast  = (state == ST_SEND) && last_r;
   assign fifo_level    = level;
   assign frame_cnt     = frame_cnt_r;

endmodule

// File: tb/tb_rx_stream_framer.sv
module tb_rx_stream_framer;
   localparam int DW     = 32;
   localparam int DEPTH  = 8;
   localparam int FL     = 4;
   localparam int TMO    = 8;
   localparam int DEPTH1 = 4;

   logic                   aclk = 1'b0;
   logic                   aresetn;
   logic [DW-1:0]          in_data, in_data1;
   logic                   in_valid, in_valid1;
   logic                   in_ready, in_ready1;
   logic [DW-1:0]          m_axis_tdata, m_axis_tdata1;
   logic                   m_axis_tvalid, m_axis_tvalid1;
   logic                   m_axis_tready, m_axis_tready1;
   logic                   m_axis_tlast, m_axis_tlast1;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [$clog2(DEPTH1):0] fifo_level1;
   logic [15:0]            frame_cnt, frame_cnt1;

   always #5 aclk = ~aclk;

   rx_stream_framer #(.DATA_W(DW), .DEPTH(DEPTH), .FRAME_LEN(FL), .TIMEOUT(TMO)) dut (
      .aclk(aclk), .aresetn(aresetn), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .fifo_level(fifo_level), .frame_cnt(frame_cnt));

   rx_stream_framer #(.DATA_W(DW), .DEPTH(DEPTH1), .FRAME_LEN(1), .TIMEOUT(TMO)) dut1 (
      .aclk(aclk), .aresetn(aresetn), .in_data(in_data1), .in_valid(in_valid1),
      .in_ready(in_ready1), .m_axis_tdata(m_axis_tdata1), .m_axis_tvalid(m_axis_tvalid1),
      .m_axis_tready(m_axis_tready1), .m_axis_tlast(m_axis_tlast1),
      .fifo_level(fifo_level1), .frame_cnt(frame_cnt1));

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t q[$];
   beat_t q1[$];
   beat_t tab1[8];
   int    n_vec = 0;
   int    n_err = 0;
   int    beats = 0;
   logic  tv_s  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sample();
      beat_t e;
      tv_s = m_axis_tvalid;
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
         beats++;
         if (q.size() == 0) chk("unexpected_beat", 1, 0);
         else begin
            e = q.pop_front();
            chk("beat_data", m_axis_tdata, e.data);
            chk("beat_last", m_axis_tlast, e.last);
         end
      end
      if (aresetn && m_axis_tvalid1 && m_axis_tready1) begin
         if (q1.size() == 0) chk("unexpected_beat_fl1", 1, 0);
         else begin
            e = q1.pop_front();
            chk("beat_data_fl1", m_axis_tdata1, e.data);
            chk("beat_last_fl1", m_axis_tlast1, e.last);
         end
      end
   endtask

   task automatic tick();
      @(negedge aclk);
      sample();
      @(posedge aclk);
      #1;
   endtask

   task automatic push(input int sel, input logic [DW-1:0] d, input logic last);
      int    g;
      beat_t e;
      g = 0;
      e.data = d;
      e.last = last;
      if (sel == 0) begin
         while (!in_ready && g < 100) begin tick(); g++; end
         if (!in_ready) chk("push_ready_timeout", in_ready, 1);
         else begin
            in_valid = 1'b1; in_data = d; q.push_back(e);
            tick();
            in_valid = 1'b0;
         end
      end else begin
         while (!in_ready1 && g < 100) begin tick(); g++; end
         if (!in_ready1) chk("push_ready_timeout_fl1", in_ready1, 1);
         else begin
            in_valid1 = 1'b1; in_data1 = d; q1.push_back(e);
            tick();
            in_valid1 = 1'b0;
         end
      end
   endtask

   task automatic drain(input int budget, input string name);
      int g;
      g = 0;
      while ((q.size() != 0 || q1.size() != 0) && g < budget) begin tick(); g++; end
      chk(name, q.size() + q1.size(), 0);
   endtask

   initial begin
      int g;
      int b0;
      for (int i = 0; i < 8; i++) begin
         tab1[i].data = 32'hA000 + i;
         tab1[i].last = ((i % FL) == FL - 1);
      end

      aresetn = 1'b0;
      in_valid = 1'b0; in_data = '0; m_axis_tready = 1'b0;
      in_valid1 = 1'b0; in_data1 = '0; m_axis_tready1 = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_in_ready", in_ready, 0);
      aresetn = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);

      // full frames, back-to-back
      m_axis_tready = 1'b1;
      for (int i = 0; i < 8; i++) push(0, tab1[i].data, tab1[i].last);
      drain(100, "t1_drain");
      chk("t1_frame_cnt", frame_cnt, 2);
      chk("t1_idle_tvalid", m_axis_tvalid, 0);

      // partial frame closed by idle timeout
      b0 = beats;
      push(0, 32'hB0A, 1'b0);
      push(0, 32'hB0B, 1'b1);
      g = 0;
      while (beats < b0 + 1 && g < 50) begin tick(); g++; end
      chk("t2_first_sent", beats - b0, 1);
      g = 0;
      tick();
      while (!tv_s && g < 100) begin g++; tick(); end
      chk("t2_timeout_gap", g, TMO);
      drain(50, "t2_drain");
      chk("t2_frame_cnt", frame_cnt, 3);
      push(0, 32'hC0C, 1'b0);
      push(0, 32'hC0D, 1'b0);
      push(0, 32'hC0E, 1'b0);
      push(0, 32'hC0F, 1'b1);
      drain(50, "t2b_drain");
      chk("t2b_frame_cnt", frame_cnt, 4);

      // back-pressure: fill FIFO plus hold register
      m_axis_tready = 1'b0;
      for (int i = 0; i <= DEPTH; i++)
         push(0, 32'hC000 + i, (i == 3) || (i == 7) || (i == DEPTH));
      chk("t3_in_ready_full", in_ready, 0);
      chk("t3_level_full", fifo_level, DEPTH);
      repeat (3) tick();
      chk("t3_hold_tvalid", m_axis_tvalid, 1);
      chk("t3_hold_tdata", m_axis_tdata, 32'hC000);
      chk("t3_hold_tlast", m_axis_tlast, 0);
      m_axis_tready = 1'b1;
      drain(200, "t3_drain");
      chk("t3_frame_cnt", frame_cnt, 7);
      chk("t3_in_ready_back", in_ready, 1);

      // timeout-SEND stalled, later word must not clear tlast
      m_axis_tready = 1'b0;
      push(0, 32'hD00, 1'b1);
      g = 0;
      while (!tv_s && g < 50) begin tick(); g++; end
      chk("t4_timeout_send", tv_s, 1);
      push(0, 32'hD01, 1'b0);
      push(0, 32'hD02, 1'b0);
      push(0, 32'hD03, 1'b0);
      push(0, 32'hD04, 1'b1);
      repeat (2) tick();
      chk("t4_tlast_kept", m_axis_tlast, 1);
      chk("t4_tdata_kept", m_axis_tdata, 32'hD00);
      m_axis_tready = 1'b1;
      drain(100, "t4_drain");
      chk("t4_frame_cnt", frame_cnt, 9);

      // FRAME_LEN = 1: every word is frame-last, no timeout wait
      for (int i = 0; i < 5; i++) push(1, 32'hF000 + i, 1'b1);
      drain(4, "t5_drain_no_timeout");
      chk("t5_frame_cnt", frame_cnt1, 5);

      // reset mid-frame with level 5
      m_axis_tready = 1'b0;
      for (int i = 0; i < 6; i++) push(0, 32'hE000 + i, 1'b0);
      chk("t6_level_before_rst", fifo_level, 5);
      #2;
      aresetn = 1'b0;
      #1;
      chk("t6_rst_tvalid", m_axis_tvalid, 0);
      chk("t6_rst_level", fifo_level, 0);
      chk("t6_rst_frame_cnt", frame_cnt, 0);
      q.delete();
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      tick();
      m_axis_tready = 1'b1;
      for (int i = 0; i < FL; i++) push(0, 32'h7000 + i, i == FL - 1);
      drain(50, "t6_drain");
      chk("t6_frame_cnt", frame_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
